// File: rtl/rs232_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding a single rs232_send transmitter.
// Optionally prefixes each packet with a source-port header byte {4'hA, port}.
module rs232_tx_arbiter #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned HEADER     = 1,
  parameter int unsigned IDLE_LIMIT = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [8*PORTS-1:0] in_data,
  input  logic [PORTS-1:0]   in_valid,
  input  logic [PORTS-1:0]   in_last,
  output logic [PORTS-1:0]   in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PORTS-1:0]   grant,
  output logic               busy,
  output logic               abort
);

  localparam int unsigned SW = ($clog2(IDLE_LIMIT + 1) > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'((IDLE_LIMIT == 0) ? 0 : IDLE_LIMIT - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  state_e           state_q;
  logic [PORTS-1:0] grant_q;
  logic [3:0]       gidx_q;
  logic [3:0]       last_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic [SW-1:0]    starve_q;
  logic             abort_q;

  logic       slot_free;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;
  logic       in_fire;
  logic [3:0] pick_idx;
  logic       pick_found;
  logic [3:0] hi_idx;
  logic       hi_found;
  logic [3:0] lo_idx;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (grant_q[i]) begin
        sel_data  = in_data[8*i +: 8];
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  // Lowest requester above last_q wins; otherwise wrap to the lowest requester.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 4'd0;
    lo_idx   = 4'd0;
    for (int i = int'(PORTS) - 1; i >= 0; i--) begin
      if (in_valid[i] && (4'(i) > last_q)) begin
        hi_found = 1'b1;
        hi_idx   = 4'(i);
      end
      if (in_valid[i]) begin
        lo_idx = 4'(i);
      end
    end
    pick_found = |in_valid;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign in_ready  = ((state_q == StData) && slot_free) ? grant_q : '0;
  assign in_fire   = (state_q == StData) && slot_free && sel_valid;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);
  assign abort     = abort_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= 4'd0;
      last_q      <= 4'(PORTS - 1);
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      starve_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q  <= PORTS'(1) << pick_idx;
            gidx_q   <= pick_idx;
            starve_q <= '0;
            state_q  <= (HEADER != 0) ? StHeader : StData;
          end
        end
        StHeader: begin
          if (slot_free) begin
            out_data_q  <= {4'hA, gidx_q};
            out_valid_q <= 1'b1;
            starve_q    <= '0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (in_fire) begin
            out_data_q  <= sel_data;
            out_valid_q <= 1'b1;
          end
          if (in_fire && sel_last) begin
            grant_q <= '0;
            last_q  <= gidx_q;
            state_q <= StIdle;
          end else if (sel_valid) begin
            starve_q <= '0;
          end else if (IDLE_LIMIT != 0) begin
            // A stalled owner gives up the transmitter; any loaded byte still drains.
            if (starve_q == StarveMax) begin
              abort_q <= 1'b1;
              grant_q <= '0;
              last_q  <= gidx_q;
              state_q <= StIdle;
            end else begin
              starve_q <= starve_q + SW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Packet-atomic round-robin arbiter that shares one `rs232_send` transmitter between up to 16 byte-stream requesters. Each granted packet is optionally prefixed with a header byte identifying the source port. The grant is held until that packet's last byte is accepted, or until a stalled requester times out. It sits directly upstream of `rs232_send`, driving its `data`/`valid` and consuming its `ready`.

## Interface
- `PORTS`, 4: number of requesters, legal range 1..16.
- `HEADER`, 1: 1 = emit header byte `{4'hA, port_index[3:0]}` before each packet; 0 = no header.
- `IDLE_LIMIT`, 1024: consecutive starved cycles before a granted packet is aborted; 0 disables the timeout.
- `clock`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  8*PORTS  byte of port i at bits [8i+7:8i].
- `in_valid`  in  PORTS  per-port byte valid.
- `in_last`  in  PORTS  per-port end-of-packet, qualified by `in_valid`.
- `in_ready`  out  PORTS  per-port accept; at most one bit is high.
- `out_data`  out  8  byte to transmitter.
- `out_valid`  out  1  byte valid to transmitter.
- `out_ready`  in  1  transmitter ready.
- `grant`  out  PORTS  one-hot current owner; 0 when idle.
- `busy`  out  1  high while a packet is owned (HEADER or DATA).
- `abort`  out  1  one-cycle pulse on timeout release.

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready, on both the input and output sides.
  - A requester must hold `in_data`/`in_last` stable while `in_valid` is high and not accepted.
  - The arbiter holds `out_data` stable while `out_valid` is high and `out_ready` is low.
- Output stage: a single register (`out_data`, `out_valid`).
  - `slot_free = !out_valid || out_ready`.
  - `out_valid` clears after an output transfer unless a new byte loads in the same cycle.
- `in_ready[g] = (state == DATA) && grant[g] && slot_free`. This is combinational from `out_ready`, which is legal because the transmitter's `ready` is registered.
- State machine:
  - **IDLE**: if any `in_valid` is set, pick the first set bit searching upward from `last+1` (mod PORTS). Set `grant`, then go to HEADER if HEADER=1, else DATA. `in_valid` is sampled only in IDLE.
  - **HEADER**: when `slot_free`, load the header byte into the output register and go to DATA.
  - **DATA**: on an input transfer, load `in_data[g]` into the output register.
    - If `in_last[g]` is set: clear `grant`, set `last = g`, go to IDLE.
  - **Timeout**: in DATA, the `starve` counter increments on each cycle where `in_valid[g] = 0`. It clears on any cycle where `in_valid[g] = 1`, including backpressured cycles.
    - If IDLE_LIMIT > 0 and `in_valid[g] = 0` on the IDLE_LIMIT-th consecutive such cycle: pulse `abort`, clear `grant`, set `last = g`, go to IDLE.
    - A byte already in the output register still drains normally.
- `starve` clears on entry to DATA. Its width is `$clog2(IDLE_LIMIT+1)`, with a minimum of 1.
- PORTS=1: round robin degenerates to always granting port 0.

## Timing
- Reset values: `out_valid` 0, `out_data` 8'h00, `grant` 0, `busy` 0, `abort` 0, `in_ready` 0, state IDLE, `last = PORTS-1` (port 0 wins first).
- Reset mid-packet: the byte in the output register is dropped and all state returns to reset values immediately (asynchronous).
- Grant latency: `in_valid` seen in IDLE at edge t gives `grant`/`busy` high after t.
- Header latency: with `slot_free`, the header appears on `out_data` after edge t+1, and the first `in_ready` comes one cycle later.
- Data latency: an input byte accepted at edge t is on `out_data` with `out_valid` after t.
  - Back-to-back throughput is 1 byte/cycle when `out_ready` stays high.
- Packet gap: after the last byte is accepted, there is at least 1 IDLE cycle before the next grant. `busy` drops in the same cycle that `grant` clears.
- Simultaneous requests: round-robin order only; no priority other than rotation from `last`.
- Abort and a returning `in_valid[g]` in the same cycle: valid wins and the counter clears.
- `in_last` asserted on the first data byte gives a 1-byte packet (header plus 1 byte).

## Test plan
- **Single port, HEADER=1, port 2 sends 8'h55, 8'h66 (last), `out_ready` held 1**: `out_data` sequence is A2, 55, 66; `grant` = 4'b0100 for 3 cycles, then 0; `abort` never asserts.
- **All four ports request continuously, 1-byte packets**: headers appear in order A0, A1, A2, A3, A0; no port is granted twice before the others.
- **`out_ready` toggles 1-0-1 during a 4-byte packet from port 1**: `out_data` stays stable while stalled; the byte order is intact; `in_ready[1]` is low on every stalled cycle.
- **IDLE_LIMIT=8, port 3 sends 1 byte (not last), then drops `in_valid`**: `abort` pulses on the 8th starved cycle, `grant` clears, and port 0's pending request is granted next.
- **IDLE_LIMIT=8, port 3 raises `in_valid` on the 8th starved cycle**: no abort; the byte is accepted.
- **`reset_n` pulsed low mid-packet with `out_valid` = 1**: all outputs return to reset values within the reset; after release, port 0 wins first arbitration.
